// File: rtl/shift_divider.sv
// -----------------------------------------------------------------------------
// shift_divider
//
// Sequential restoring (shift-subtract) unsigned divider. Produces one
// quotient bit per clock. The start/ready handshake is the same as the
// shift-add multiplier sequencer, so the two blocks can sit side by side.
//
// Parameters:
//   n          operand width in bits (n >= 2)
//
// Ports:
//   clock      input   1   system clock, rising-edge active
//   reset      input   1   asynchronous, active-high reset
//   start      input   1   request a division, sampled only while ready=1
//   Dividend   input   n   unsigned dividend, sampled on the accepting edge
//   Divisor    input   n   unsigned divisor, sampled on the accepting edge
//   Quotient   output  n   last completed quotient
//   Remainder  output  n   last completed remainder
//   ready      output  1   1 = idle/done (can accept start), 0 = busy
//   dbz        output  1   divide-by-zero flag of the last completed operation
//
// Build option:
//   SHIFT_DIVIDER_DBZ_EN  when defined, a zero divisor skips the iteration
//                         and completes immediately with Quotient=all ones,
//                         Remainder=Dividend and dbz=1. When undefined, dbz
//                         is tied to 0 and a zero divisor runs the normal
//                         n-cycle algorithm.
// -----------------------------------------------------------------------------
module shift_divider #(
  parameter int n = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] Dividend,
  input  logic [n-1:0] Divisor,
  output logic [n-1:0] Quotient,
  output logic [n-1:0] Remainder,
  output logic         ready,
  output logic         dbz
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [n:0]     a_q, a_d;         // partial remainder
  logic [n-1:0]   q_q, q_d;         // dividend shifting out / quotient shifting in
  logic [n-1:0]   d_q, d_d;         // latched divisor
  logic [CW-1:0]  count_q, count_d; // steps remaining
  logic [n-1:0]   quo_q, quo_d;
  logic [n-1:0]   rem_q, rem_d;

  logic           accept;
  logic [n:0]     a_shift;
  logic [n-1:0]   q_shift;
  logic [n+1:0]   trial;

`ifdef SHIFT_DIVIDER_DBZ_EN
  logic           dbz_q, dbz_d;
`endif

  // One shift-subtract step. The top bit of A is always 0 here because the
  // restored partial remainder is below D, so dropping it loses nothing.
  always_comb begin
    a_shift = {a_q[n-1:0], q_q[n-1]};
    q_shift = {q_q[n-2:0], 1'b0};
    trial   = {1'b0, a_shift} - {2'b00, d_q};
  end

  assign ready  = (state_q != RUN);
  assign accept = start & ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    d_d     = d_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef SHIFT_DIVIDER_DBZ_EN
    dbz_d   = dbz_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef SHIFT_DIVIDER_DBZ_EN
          if (Divisor == '0) begin
            // Complete on the accepting edge; ready never drops.
            quo_d   = '1;
            rem_d   = Dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = '0;
            q_d     = Dividend;
            d_d     = Divisor;
            count_d = CW'(n);
            dbz_d   = 1'b0;
            state_d = RUN;
          end
`else
          a_d     = '0;
          q_d     = Dividend;
          d_d     = Divisor;
          count_d = CW'(n);
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        if (!trial[n+1]) begin
          // Subtraction fits: keep the difference, quotient bit = 1.
          a_d = trial[n:0];
          q_d = q_shift | {{(n-1){1'b0}}, 1'b1};
        end else begin
          // Restore: keep the shifted value, quotient bit = 0.
          a_d = a_shift;
          q_d = q_shift;
        end
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          quo_d   = q_d;
          rem_d   = a_d[n-1:0];
`ifdef SHIFT_DIVIDER_DBZ_EN
          dbz_d   = 1'b0;
`endif
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef SHIFT_DIVIDER_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef SHIFT_DIVIDER_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
`ifdef SHIFT_DIVIDER_DBZ_EN
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_shift_divider.sv
// -----------------------------------------------------------------------------
// tb_shift_divider
//
// Directed bench for shift_divider with n=4: reset state, latency, back-to-back
// operation, divide-by-zero (either build), ignored mid-run start, abort by
// reset, and a sweep over every nonzero-divisor operand pair.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_divider;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] Dividend = '0;
  logic [N-1:0] Divisor = '0;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         ready;
  logic         dbz;

  int checks = 0;
  int failures = 0;

  shift_divider #(.n(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .ready     (ready),
    .dbz       (dbz)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Launch one division and count the samples with ready=0 after the
  // accepting edge (bounded so a stuck DUT cannot hang the run).
  task automatic do_div(input int dd, input int dv, output int lat);
    Dividend = dd[N-1:0];
    Divisor  = dv[N-1:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 50) begin
      lat++;
      tick();
    end
  endtask

  int lat;
  int exp_lat;

  initial begin
    // Reset state
    #2;
    check("rst_ready", ready, 1);
    check("rst_quo", Quotient, 0);
    check("rst_rem", Remainder, 0);
    check("rst_dbz", dbz, 0);
    tick();
    reset = 1'b0;
    tick();

    // 13 / 3
    do_div(13, 3, lat);
    check("13_3_lat", lat, 4);
    check("13_3_quo", Quotient, 4);
    check("13_3_rem", Remainder, 1);
    check("13_3_dbz", dbz, 0);
    $display("txn 13/3 -> Q=%0d R=%0d latency=%0d", Quotient, Remainder, lat);

    // 15 / 1 then 5 / 7 back-to-back with start held
    Dividend = 4'd15; Divisor = 4'd1; start = 1'b1;
    tick();
    check("b2b_busy", ready, 0);
    Dividend = 4'd5; Divisor = 4'd7;   // ignored during RUN
    tick();
    check("b2b_hold_quo", Quotient, 4);
    check("b2b_hold_rem", Remainder, 1);
    tick(); tick(); tick();
    check("b2b1_ready", ready, 1);
    check("b2b1_quo", Quotient, 15);
    check("b2b1_rem", Remainder, 0);
    $display("txn 15/1 -> Q=%0d R=%0d", Quotient, Remainder);
    tick();                              // second accept, no dead cycle
    check("b2b2_busy", ready, 0);
    start = 1'b0;
    lat = 1;
    while (ready !== 1'b1 && lat < 50) begin
      tick();
      if (ready !== 1'b1) lat++;
    end
    check("b2b2_lat", lat, 4);
    check("b2b2_quo", Quotient, 0);
    check("b2b2_rem", Remainder, 5);
    $display("txn 5/7 -> Q=%0d R=%0d", Quotient, Remainder);

    // 9 / 0
`ifdef SHIFT_DIVIDER_DBZ_EN
    exp_lat = 0;
`else
    exp_lat = 4;
`endif
    do_div(9, 0, lat);
    check("dz_lat", lat, exp_lat);
    check("dz_quo", Quotient, 15);
    check("dz_rem", Remainder, 9);
`ifdef SHIFT_DIVIDER_DBZ_EN
    check("dz_dbz", dbz, 1);
`else
    check("dz_dbz", dbz, 0);
`endif
    $display("txn 9/0 -> Q=%0d R=%0d dbz=%0d latency=%0d", Quotient, Remainder, dbz, lat);

    // 12 / 5 with a second start pulse (1/1) in cycle 2 of RUN
    Dividend = 4'd12; Divisor = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_dbz_clear", dbz, 0);
    Dividend = 4'd1; Divisor = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 50) begin
      lat++;
      tick();
    end
    check("ign_lat", lat, 3);
    check("ign_quo", Quotient, 2);
    check("ign_rem", Remainder, 2);
    tick();
    check("ign_no_restart", ready, 1);
    $display("txn 12/5 (mid-run start ignored) -> Q=%0d R=%0d", Quotient, Remainder);

    // 14 / 4 aborted by reset after 2 RUN cycles
    Dividend = 4'd14; Divisor = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_quo", Quotient, 0);
    check("abort_rem", Remainder, 0);
    tick();
    reset = 1'b0;
    tick();
    do_div(14, 4, lat);
    check("14_4_lat", lat, 4);
    check("14_4_quo", Quotient, 3);
    check("14_4_rem", Remainder, 2);
    $display("txn 14/4 after abort -> Q=%0d R=%0d", Quotient, Remainder);

    // Sweep every pair with a nonzero divisor
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 1; dv < 16; dv++) begin
        do_div(dd, dv, lat);
        check($sformatf("sw_lat_%0d_%0d", dd, dv), lat, 4);
        check($sformatf("sw_quo_%0d_%0d", dd, dv), Quotient, dd / dv);
        check($sformatf("sw_rem_%0d_%0d", dd, dv), Remainder, dd % dv);
        check($sformatf("sw_rlt_%0d_%0d", dd, dv), int'(Remainder < dv[N-1:0]), 1);
      end
    end
    $display("txn sweep of 240 operand pairs complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
